arm_imm_encoder: RTL and testbench

- Inverse of the data-processing immediate operand decode. Takes a 32-bit constant and searches for an ARM rotated-immediate encoding {rotate_imm[3:0], immed_8[7:0]}, where value = ROR(immed_8, 2*rotate_imm).
- Used by the program loader and test harness to build I-bit data-processing instructions (bits [11:0]) before writing them to instruction memory.
- Iterative: evaluates one rotation candidate per clock under a start/busy/done handshake.

---
 rtl/arm_imm_encoder.sv | 167 ++++++++++++++++
 tb/tb_arm_imm_encoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/arm_imm_encoder.sv
// Iterative ARM rotated-immediate encoder: searches one rotation per clock for value = ROR(imm8, 2*rot).
// Optional second pass on ~value (MVN/BIC form) is enabled with `define IMM_ENCODER_INVERT_EN.
module arm_imm_encoder #(
    parameter int unsigned NUM_ROT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [7:0]  imm8,
    output logic [3:0]  rot,
    output logic [11:0] imm_field,
    output logic        inverted
);

    localparam int unsigned DW = 32;
    localparam int unsigned IW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned SW = 5;
    localparam logic [CW-1:0] LAST_ROT = CW'(NUM_ROT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic [DW-1:0] latched_q, latched_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          found_q, found_n;
    logic [IW-1:0] imm8_q, imm8_n;
    logic [CW-1:0] rot_q, rot_n;

    logic [DW-1:0] src;
    logic [SW-1:0] shamt;
    logic [DW-1:0] cand;

`ifdef IMM_ENCODER_INVERT_EN
    logic pass_q, pass_n;
    logic inv_q, inv_n;
    assign src      = pass_q ? ~latched_q : latched_q;
    assign inverted = inv_q;
`else
    assign src      = latched_q;
    assign inverted = 1'b0;
`endif

    // Candidate is ROL(src, 2*r); shift width wraps mod 32
    assign shamt = {cnt_q, 1'b0};
    assign cand  = (src << shamt) | (src >> (6'd32 - {1'b0, shamt}));

    assign busy      = busy_q;
    assign done      = done_q;
    assign found     = found_q;
    assign imm8      = imm8_q;
    assign rot       = rot_q;
    assign imm_field = {rot_q, imm8_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            latched_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            imm8_q    <= '0;
            rot_q     <= '0;
`ifdef IMM_ENCODER_INVERT_EN
            pass_q    <= 1'b0;
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            latched_q <= latched_n;
            cnt_q     <= cnt_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            found_q   <= found_n;
            imm8_q    <= imm8_n;
            rot_q     <= rot_n;
`ifdef IMM_ENCODER_INVERT_EN
            pass_q    <= pass_n;
            inv_q     <= inv_n;
`endif
        end
    end

    always_comb begin
        state_n   = state_q;
        latched_n = latched_q;
        cnt_n     = cnt_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        found_n   = found_q;
        imm8_n    = imm8_q;
        rot_n     = rot_q;
`ifdef IMM_ENCODER_INVERT_EN
        pass_n    = pass_q;
        inv_n     = inv_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    latched_n = value;
                    cnt_n     = '0;
                    busy_n    = 1'b1;
                    found_n   = 1'b0;
                    state_n   = SEARCH;
`ifdef IMM_ENCODER_INVERT_EN
                    pass_n    = 1'b0;
                    inv_n     = 1'b0;
`endif
                end
            end
            SEARCH: begin
                if (cand[DW-1:IW] == '0) begin
                    imm8_n  = cand[IW-1:0];
                    rot_n   = cnt_q;
                    found_n = 1'b1;
                    done_n  = 1'b1;
                    state_n = DONE;
`ifdef IMM_ENCODER_INVERT_EN
                    inv_n   = pass_q;
`endif
                end else if (cnt_q == LAST_ROT) begin
`ifdef IMM_ENCODER_INVERT_EN
                    if (!pass_q) begin
                        pass_n = 1'b1;
                        cnt_n  = '0;
                    end else begin
                        found_n = 1'b0;
                        imm8_n  = '0;
                        rot_n   = '0;
                        inv_n   = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
`else
                    found_n = 1'b0;
                    imm8_n  = '0;
                    rot_n   = '0;
                    done_n  = 1'b1;
                    state_n = DONE;
`endif
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Table-driven bench for arm_imm_encoder; honours IMM_ENCODER_INVERT_EN for the inverted-pass vectors.
module tb_arm_imm_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        found;
    logic [7:0]  imm8;
    logic [3:0]  rot;
    logic [11:0] imm_field;
    logic        inverted;

    int checks;
    int errors;

    arm_imm_encoder #(.NUM_ROT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .imm8      (imm8),
        .rot       (rot),
        .imm_field (imm_field),
        .inverted  (inverted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          edges;
        logic        fnd;
        logic [7:0]  i8;
        logic [3:0]  r;
        logic        inv;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue start at a negedge; edge 0 samples it. Returns the edge index where done is seen (-1 on timeout).
    task automatic launch(input logic [31:0] v);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        value = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(output int edges);
        edges = -1;
        // Already past edge 0 negedge; edge 1 is next
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = e;
                break;
            end
        end
    endtask

    vec_t vecs[$];
    int   got_edges;
    logic saw_done;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        value  = '0;

        vecs.push_back('{32'h0000_00FF, 1,  1'b1, 8'hFF, 4'd0,  1'b0});
        vecs.push_back('{32'hFF00_0000, 5,  1'b1, 8'hFF, 4'd4,  1'b0});
        vecs.push_back('{32'hF000_000F, 3,  1'b1, 8'hFF, 4'd2,  1'b0});
        vecs.push_back('{32'h0000_03FC, 16, 1'b1, 8'hFF, 4'd15, 1'b0});
        vecs.push_back('{32'h0000_0000, 1,  1'b1, 8'h00, 4'd0,  1'b0});
        vecs.push_back('{32'h0000_0104, 16, 1'b1, 8'h41, 4'd15, 1'b0});
`ifdef IMM_ENCODER_INVERT_EN
        vecs.push_back('{32'h0000_0101, 32, 1'b0, 8'h00, 4'd0,  1'b0});
        vecs.push_back('{32'hFFFF_FF00, 17, 1'b1, 8'hFF, 4'd0,  1'b1});
`else
        vecs.push_back('{32'h0000_0101, 16, 1'b0, 8'h00, 4'd0,  1'b0});
        vecs.push_back('{32'hFFFF_FF00, 16, 1'b0, 8'h00, 4'd0,  1'b0});
`endif

        // Reset state, also with start asserted (reset wins)
        @(negedge clk);
        start = 1'b1;
        value = 32'h0000_00FF;
        @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_outs", {19'd0, found, inverted, imm_field}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;

        // Reset mid-search: no done pulse, outputs return to zero
        launch(32'h0000_0101);
        saw_done = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            saw_done |= done;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        saw_done |= done;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_outs", {19'd0, found, inverted, imm_field}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            saw_done |= done;
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);

        // Vector table
        foreach (vecs[i]) begin
            launch(vecs[i].val);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            wait_done(got_edges);
            check($sformatf("v%0d_latency", i), 32'(got_edges), 32'(vecs[i].edges));
            check($sformatf("v%0d_found", i), 32'(found), 32'(vecs[i].fnd));
            check($sformatf("v%0d_imm8", i), 32'(imm8), 32'(vecs[i].i8));
            check($sformatf("v%0d_rot", i), 32'(rot), 32'(vecs[i].r));
            check($sformatf("v%0d_field", i), 32'(imm_field), {20'd0, vecs[i].r, vecs[i].i8});
            check($sformatf("v%0d_inv", i), 32'(inverted), 32'(vecs[i].inv));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_width", i), 32'(done), 32'd0);
            check($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
        end

        // Start while busy is ignored; result holds until next start
        launch(32'hFF00_0000);
        @(negedge clk);
        start = 1'b1;
        value = 32'h0000_00FF;
        @(negedge clk);
        start = 1'b0;
        // Two edges consumed since edge 0 (edges 1 and 2)
        got_edges = -1;
        for (int e = 3; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got_edges = e;
                break;
            end
        end
        check("ign_latency", 32'(got_edges), 32'd5);
        check("ign_field", 32'(imm_field), 32'h0000_04FF);
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            #1;
        end
        check("hold_done", 32'(done), 32'd0);
        check("hold_field", 32'(imm_field), 32'h0000_04FF);
        check("hold_found", 32'(found), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
